// File: rtl/dmem_requester.sv
// Purpose: drives the data memory's memread/memwrite strobes for one load/store at a time.
// Latency: resp_valid 3 edges after the accept edge for a normal access (1 edge for a trapped misalign).
// Backpressure: req_ready only in IDLE with the memory not stalling; requests are held upstream otherwise.
//
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned half/word accesses without touching memory.
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   req_valid/req_ready            pipeline request handshake
//   req_write/addr/wdata/size/     request payload (size: 0=byte, 1=half, 2/3=word)
//   req_unsigned
//   resp_valid/rdata/err           one-cycle response; rdata/err hold until the next response
//   mem_addr/write_data/memwrite/  registered memory-side request
//   memread/sign_mask
//   mem_read_data/mem_clk_stall    memory-side returns
module dmem_requester #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value at the start of the last permitted WAIT cycle.
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          seen_stall;
    logic          is_load;
    logic [2:0]    size_mask;

    // Holding off while stall is high keeps a new request from colliding with an
    // access that memory is still finishing (e.g. one orphaned by a reset).
    assign req_ready = (state == IDLE) && !mem_clk_stall;

    always_comb begin
        size_mask = 3'b111;
        case (req_size)
            2'd0:    size_mask = 3'b001;
            2'd1:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign;
    always_comb begin
        misalign = 1'b0;
        if (req_size == 2'd1)
            misalign = req_addr[0];
        else if (req_size[1])
            misalign = (req_addr[1:0] != 2'b00);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            seen_stall     <= 1'b0;
            is_load        <= 1'b0;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h0;
            resp_err       <= 1'b0;
            mem_addr       <= 32'h0;
            mem_write_data <= 32'h0;
            mem_memwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_sign_mask  <= 4'h0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        mem_addr       <= req_addr;
                        mem_write_data <= req_wdata;
                        mem_sign_mask  <= {~req_write & ~req_unsigned, size_mask};
                        is_load        <= ~req_write;
`ifdef MISALIGN_TRAP_EN
                        if (misalign) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end else
`endif
                        begin
                            mem_memwrite <= req_write;
                            mem_memread  <= ~req_write;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_memwrite <= 1'b0;
                    mem_memread  <= 1'b0;
                    wait_cnt     <= '0;
                    seen_stall   <= 1'b0;
                    state        <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (mem_clk_stall)
                        seen_stall <= 1'b1;
                    // Completion is the falling edge of stall after it was seen high.
                    if (seen_stall && !mem_clk_stall) begin
                        resp_rdata <= is_load ? mem_read_data : 32'h0;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_requester.sv
// Purpose: self-checking bench for dmem_requester with a stalling memory model and response scoreboard.
// Latency: checks resp_valid timing relative to the accept edge for each vector.
// Backpressure: req_valid is held until req_ready is seen, bounded by a cycle budget.
module tb_dmem_requester;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = 32'h0;
    logic        mem_clk_stall = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_requester #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_sign_mask  (mem_sign_mask),
        .mem_read_data  (mem_read_data),
        .mem_clk_stall  (mem_clk_stall)
    );

    // Memory model: samples a strobe on the edge, then holds stall for stall_len cycles.
    logic        stall_en = 1'b1;
    int          stall_len = 1;
    int          st_cnt = 0;
    logic [31:0] model_rdata = 32'h0;

    always @(posedge clk) begin
        if (stall_en && (mem_memread || mem_memwrite)) begin
            mem_clk_stall <= 1'b1;
            st_cnt        <= stall_len;
            mem_read_data <= mem_memread ? model_rdata : 32'h0;
        end else if (st_cnt > 1) begin
            st_cnt <= st_cnt - 1;
        end else begin
            st_cnt        <= 0;
            mem_clk_stall <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_r;

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", {31'b0, resp_valid}, 32'h0);
            end else begin
                mon_r = exp_q.pop_front();
                check("resp_rdata", resp_rdata, mon_r.rdata);
                check("resp_err", {31'b0, resp_err}, {31'b0, mon_r.err});
            end
        end
    end

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] mrd;     // data the memory model returns
        logic [3:0]  mask;    // expected mem_sign_mask
        logic [31:0] rd;      // expected resp_rdata
        logic        err;     // expected resp_err
        logic        strobe;  // a strobe is expected
        int          lat;     // negedge index (after accept) where resp_valid is first seen
    } vec_t;

    vec_t vecs[7];
    vec_t tmo_vec;
    vec_t mis_vec;

    task automatic do_req(input vec_t v);
        bit    ok;
        int    rd_cyc, wr_cyc, resp_at, resp_cnt;
        resp_t r;
        @(negedge clk);
        req_write    = v.w;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_size     = v.size;
        req_unsigned = v.uns;
        model_rdata  = v.mrd;
        req_valid    = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_accept", {31'b0, ok}, 32'h1);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        r.rdata = v.rd;
        r.err   = v.err;
        exp_q.push_back(r);
        rd_cyc = 0;
        wr_cyc = 0;
        resp_at = 0;
        resp_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("issue_addr", mem_addr, v.addr);
                check("issue_mask", {28'b0, mem_sign_mask}, {28'b0, v.mask});
                if (v.w)
                    check("issue_wdata", mem_write_data, v.wdata);
            end
            if (mem_memread)  rd_cyc++;
            if (mem_memwrite) wr_cyc++;
            if (resp_valid) begin
                resp_cnt++;
                if (resp_at == 0) begin
                    resp_at = k;
                    check("addr_stable", mem_addr, v.addr);
                    check("mask_stable", {28'b0, mem_sign_mask}, {28'b0, v.mask});
                end
            end
        end
        check("memread_cycles", rd_cyc, (v.strobe && !v.w) ? 1 : 0);
        check("memwrite_cycles", wr_cyc, (v.strobe && v.w) ? 1 : 0);
        check("resp_latency", resp_at, v.lat);
        check("resp_pulses", resp_cnt, 1);
        check("resp_hold_err", {31'b0, resp_err}, {31'b0, v.err});
        check("resp_hold_rdata", resp_rdata, v.rd);
    endtask

    initial begin
        //           w  addr          wdata         sz    uns  mrd           mask     rd            err strobe lat
        vecs[0] = '{1'b0, 32'h0000_1004, 32'h0,        2'd2, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b1, 4};
        vecs[1] = '{1'b1, 32'h0000_2000, 32'h0000_005A, 2'd0, 1'b0, 32'h7777_7777, 4'b0001, 32'h0,        1'b0, 1'b1, 4};
        vecs[2] = '{1'b0, 32'h0000_1006, 32'h0,        2'd1, 1'b0, 32'hFFFF_8001, 4'b1011, 32'hFFFF_8001, 1'b0, 1'b1, 4};
        vecs[3] = '{1'b0, 32'h0000_1003, 32'h0,        2'd0, 1'b1, 32'h0000_00A5, 4'b0001, 32'h0000_00A5, 1'b0, 1'b1, 4};
        vecs[4] = '{1'b1, 32'h0000_1008, 32'h1234_5678, 2'd2, 1'b0, 32'h5555_5555, 4'b0111, 32'h0,        1'b0, 1'b1, 4};
        vecs[5] = '{1'b0, 32'h0000_100C, 32'h0,        2'd3, 1'b1, 32'hCAFE_F00D, 4'b0111, 32'hCAFE_F00D, 1'b0, 1'b1, 4};
        vecs[6] = '{1'b1, 32'h0000_100A, 32'h0000_BEEF, 2'd1, 1'b1, 32'h0,        4'b0011, 32'h0,        1'b0, 1'b1, 4};
        // Memory never stalls: 8 WAIT cycles then an error response.
        tmo_vec = '{1'b0, 32'h0000_1010, 32'h0,        2'd2, 1'b0, 32'h1111_1111, 4'b1111, 32'h0,        1'b1, 1'b1, 10};
`ifdef MISALIGN_TRAP_EN
        mis_vec = '{1'b0, 32'h0000_1002, 32'h0,        2'd2, 1'b0, 32'h1357_2468, 4'b1111, 32'h0,        1'b1, 1'b0, 1};
`else
        mis_vec = '{1'b0, 32'h0000_1002, 32'h0,        2'd2, 1'b0, 32'h1357_2468, 4'b1111, 32'h1357_2468, 1'b0, 1'b1, 4};
`endif

        // Reset state.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_strobes", {30'b0, mem_memread, mem_memwrite}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        check("rst_mask", {28'b0, mem_sign_mask}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);

        for (int i = 0; i < 7; i++)
            do_req(vecs[i]);

        // Timeout, then a normal access must still be served.
        stall_en = 1'b0;
        do_req(tmo_vec);
        stall_en = 1'b1;
        do_req(vecs[0]);

        do_req(mis_vec);

        // Reset during WAIT with a long memory stall: no response, ready waits for stall to drop.
        stall_len = 3;
        begin
            int rv_cnt;
            rv_cnt = 0;
            @(negedge clk);
            req_write    = 1'b0;
            req_addr     = 32'h0000_1020;
            req_size     = 2'd2;
            req_unsigned = 1'b0;
            model_rdata  = 32'hABCD_0123;
            req_valid    = 1'b1;
            check("rstseq_ready_idle", {31'b0, req_ready}, 32'h1);
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            if (resp_valid) rv_cnt++;
            @(negedge clk);
            if (resp_valid) rv_cnt++;
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("rstseq_ready_k3", {31'b0, req_ready}, 32'h0);
            @(negedge clk);
            check("rstseq_ready_k4", {31'b0, req_ready}, 32'h0);
            @(negedge clk);
            check("rstseq_ready_k5", {31'b0, req_ready}, 32'h1);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (resp_valid) rv_cnt++;
            end
            check("rstseq_no_resp", rv_cnt, 0);
        end
        stall_len = 1;

        do_req(vecs[1]);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
